// File: rtl/cgra_pkg.sv
// Shared CGRA types and constants: write-port arbiter state encoding and the
// round-robin successor helper.
package cgra_pkg;

    localparam int unsigned RF_ARB_N_REQ_DEFAULT = 3;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } rf_arb_state_t;

    // Index following id in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req bit at or after
// ptr, wrapping around. Outputs a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned N    = 3,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing a reg_file write port among N_REQ producers, with a
// ce-gated registered output stage. Optional burst lock: CGRA_RF_ARB_LOCK_EN.
module reg_file_wr_arbiter
    import cgra_pkg::*;
#(
    parameter int unsigned N_REQ         = RF_ARB_N_REQ_DEFAULT,
    parameter int unsigned REGFILE_DEPTH = 4,
    parameter int unsigned REGFILE_NSEL  = $clog2(REGFILE_DEPTH),
    parameter int unsigned REGFILE_WIDTH = 32,
    parameter int unsigned ID_W          = $clog2(N_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 ce_i,
    input  logic [N_REQ-1:0]                     req_valid_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    input  logic [N_REQ-1:0][REGFILE_NSEL-1:0]   req_wsel_i,
    input  logic [N_REQ-1:0][REGFILE_WIDTH-1:0]  req_data_i,
    input  logic [N_REQ-1:0]                     req_lock_i,
    output logic                                 rf_we_o,
    output logic [REGFILE_NSEL-1:0]              rf_wsel_o,
    output logic [REGFILE_WIDTH-1:0]             rf_data_o,
    output logic [ID_W-1:0]                      grant_id_o
);

    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]         arb_req;
    logic [N_REQ-1:0]         gnt;
    logic [ID_W-1:0]          gnt_id;
    logic [ID_W-1:0]          next_ptr;
    logic                     hs;

    logic                     rf_we_q;
    logic [REGFILE_NSEL-1:0]  rf_wsel_q;
    logic [REGFILE_WIDTH-1:0] rf_data_q;
    logic [ID_W-1:0]          grant_id_q;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req    (arb_req),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Ready is suppressed while stalled or in reset so no handshake can slip through.
    assign req_ready_o = (ce_i && !rst_i) ? gnt : '0;
    assign hs          = |(req_valid_i & req_ready_o);
    assign next_ptr    = ID_W'(rr_next(32'(gnt_id), N_REQ));

`ifdef CGRA_RF_ARB_LOCK_EN
    rf_arb_state_t    state_q, state_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [N_REQ-1:0] lock_mask;

    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
        arb_req = (state_q == LOCKED) ? (req_valid_i & lock_mask) : req_valid_i;
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (hs) begin
                    rr_ptr_d = next_ptr;
                    if (req_lock_i[gnt_id]) begin
                        state_d   = LOCKED;
                        lock_id_d = gnt_id;
                    end
                end
            end
            LOCKED: begin
                // Pointer stays frozen during the burst and resumes after the holder.
                if (!req_lock_i[lock_id_q]) begin
                    state_d  = ARB;
                    rr_ptr_d = ID_W'(rr_next(32'(lock_id_q), N_REQ));
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    logic unused_lock;

    assign arb_req     = req_valid_i;
    assign rr_ptr_d    = hs ? next_ptr : rr_ptr_q;
    assign unused_lock = ^req_lock_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output stage freezes while ce_i=0 so the held write commits exactly once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= '0;
            rf_data_q  <= '0;
            grant_id_q <= '0;
        end else if (ce_i) begin
            rf_we_q <= hs;
            if (hs) begin
                rf_wsel_q  <= req_wsel_i[gnt_id];
                rf_data_q  <= req_data_i[gnt_id];
                grant_id_q <= gnt_id;
            end
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_wsel_o  = rf_wsel_q;
    assign rf_data_o  = rf_data_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Self-checking bench for reg_file_wr_arbiter: directed scenarios plus randomized
// traffic against a cycle-level reference model and an emulated downstream reg_file.
module tb_reg_file_wr_arbiter;

    localparam int N = 3;
    localparam int D = 4;
`ifdef CGRA_RF_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic [N-1:0]      valid;
    logic [N-1:0]      ready;
    logic [N-1:0][1:0] wsel;
    logic [N-1:0][31:0] data;
    logic [N-1:0]      lock;
    logic              rf_we;
    logic [1:0]        rf_wsel;
    logic [31:0]       rf_data;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    reg_file_wr_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ce_i        (ce),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_wsel_i  (wsel),
        .req_data_i  (data),
        .req_lock_i  (lock),
        .rf_we_o     (rf_we),
        .rf_wsel_o   (rf_wsel),
        .rf_data_o   (rf_data),
        .grant_id_o  (grant_id)
    );

    // Downstream reg_file emulation, clock-enabled by the same ce.
    logic [31:0] tb_rf [D];
    int          wcnt  [D];
    initial for (int i = 0; i < D; i++) wcnt[i] = 0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) tb_rf[i] <= '0;
        end else if (ce && rf_we) begin
            tb_rf[rf_wsel] <= rf_data;
            wcnt[rf_wsel]  <= wcnt[rf_wsel] + 1;
        end
    end

    // Reference model state.
    int          m_ptr, m_id, m_lock_id;
    bit          m_we, m_locked;
    logic [1:0]  m_wsel;
    logic [31:0] m_data;
    logic [31:0] m_rf [D];

    int n_cmp = 0;
    int n_bad = 0;
    bit auto_drop = 1'b0;
    int last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int g;
        if (rst || !ce) return -1;
        for (int k = 0; k < N; k++) begin
            g = (m_ptr + k) % N;
            if (m_locked && g != m_lock_id) continue;
            if (valid[g]) return g;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        if (rst) begin
            m_ptr = 0; m_we = 0; m_wsel = 0; m_data = 0; m_id = 0;
            m_locked = 0; m_lock_id = 0;
            for (int i = 0; i < D; i++) m_rf[i] = '0;
        end else begin
            if (ce && m_we) m_rf[m_wsel] = m_data;
            if (ce) begin
                m_we = (g >= 0);
                if (g >= 0) begin
                    m_wsel = wsel[g]; m_data = data[g]; m_id = g;
                end
            end
            if (m_locked) begin
                if (!lock[m_lock_id]) begin
                    m_locked = 0;
                    m_ptr    = (m_lock_id + 1) % N;
                end
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (LOCK_EN && lock[g]) begin
                    m_locked  = 1;
                    m_lock_id = g;
                end
            end
        end
    endtask

    // One clock: check ready before the edge, update model, check outputs after.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", ready, exp_rdy);
        @(posedge clk);
        model_edge(g);
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_wsel", rf_wsel, m_wsel);
        chk("rf_data", rf_data, m_data);
        chk("grant_id", grant_id, m_id);
        last_g = g;
        if (auto_drop && g >= 0) valid[g] = 1'b0;
    endtask

    initial begin
        int w2;
        rst = 1'b1; ce = 1'b1; valid = '1; lock = '0;
        for (int i = 0; i < N; i++) begin
            wsel[i] = 2'(i);
            data[i] = 32'h100 + 32'(i);
        end

        // Reset with all requesters valid.
        cycle();
        chk("rst_ready", ready, 3'b000);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_data", rf_data, 32'h0);
        chk("rst_id", grant_id, 2'd0);

        // Round-robin with continuous valid.
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_id", grant_id, 64'(k % 3));
            chk("rr_we", rf_we, 1'b1);
            chk("rr_data", rf_data, 64'(32'h100 + 32'(k % 3)));
        end

        // Stall: a write captured just before ce drops commits once on return.
        valid = 3'b010; wsel[1] = 2'd2; data[1] = 32'hDEADBEEF;
        wsel[0] = 2'd0; data[0] = 32'hA0; wsel[2] = 2'd1; data[2] = 32'hA2;
        cycle();
        chk("stall_hs_id", grant_id, 2'd1);
        w2 = wcnt[2];
        valid = 3'b101; ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", ready, 3'b000);
            chk("stall_we", rf_we, 1'b1);
            chk("stall_data", rf_data, 32'hDEADBEEF);
        end
        chk("stall_no_commit", wcnt[2], w2);
        ce = 1'b1;
        cycle();
        chk("stall_commit_val", tb_rf[2], 32'hDEADBEEF);
        chk("stall_commit_cnt", wcnt[2], w2 + 1);
        valid = 3'b001;
        cycle();
        chk("stall_once", wcnt[2], w2 + 1);

        // Same-register conflict from rr_ptr=0: later grant wins.
        rst = 1'b1; valid = '0;
        cycle();
        rst = 1'b0; auto_drop = 1'b1;
        valid = 3'b101; wsel[0] = 2'd3; wsel[2] = 2'd3;
        data[0] = 32'h11; data[2] = 32'h22;
        cycle();
        chk("conf_first", grant_id, 2'd0);
        cycle();
        chk("conf_second", grant_id, 2'd2);
        cycle();
        cycle();
        chk("conf_reg3", tb_rf[3], 32'h22);

        // Reset while a write is pending in the output stage.
        auto_drop = 1'b0; valid = 3'b111;
        for (int i = 0; i < N; i++) wsel[i] = 2'(i);
        cycle();
        chk("mid_we_pre", rf_we, 1'b1);
        rst = 1'b1;
        cycle();
        chk("mid_we", rf_we, 1'b0);
        for (int i = 0; i < D; i++) chk("mid_rf_clr", tb_rf[i], 32'h0);
        rst = 1'b0;
        cycle();
        chk("mid_first_grant", grant_id, 2'd0);

`ifdef CGRA_RF_ARB_LOCK_EN
        // Burst lock by requester 1 while others wait.
        rst = 1'b1; valid = '0;
        cycle();
        rst = 1'b0; valid = 3'b010; lock = 3'b010;
        cycle();
        chk("lock_first", grant_id, 2'd1);
        valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            data[1] = 32'h200 + 32'(k);
            cycle();
            chk("lock_hold", grant_id, 2'd1);
        end
        lock = 3'b000;
        cycle();
        chk("lock_last", grant_id, 2'd1);
        cycle();
        chk("lock_after", grant_id, 2'd2);
`endif

        // Randomized traffic; requesters hold their request until accepted.
        rst = 1'b1; valid = '0; lock = '0;
        cycle();
        rst = 1'b0; auto_drop = 1'b1;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && ($urandom % 3 == 0)) begin
                    valid[i] = 1'b1;
                    wsel[i]  = 2'($urandom_range(0, 3));
                    data[i]  = $urandom;
                end
                if ($urandom % 4 == 0) lock[i] = ~lock[i];
            end
            ce  = ($urandom % 5 != 0);
            rst = ($urandom % 60 == 0);
            cycle();
            for (int i = 0; i < D; i++) chk("rand_rf", tb_rf[i], m_rf[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
